// File: rtl/iic_pkg.sv
// Shared encodings for the IIC request arbiter: FSM states, controller command codes and
// default timing limits.
package iic_pkg;

  typedef enum logic [2:0] {
    StArb,
    StIssue,
    StWaitHi,
    StWaitLo,
    StDone
  } iic_state_e;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_WR   = 2'b10;

  localparam int unsigned ISSUE_MAX_DEFAULT = 4095;

  // Round-robin pointer width; wide enough for up to four requesters.
  localparam int unsigned PTR_W = 2;

endpackage

// File: rtl/iic_rr_pick.sv
// Combinational round-robin winner select: the first requester after ptr_i (wrapping) wins.
module iic_rr_pick
  import iic_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  pick_o
);

  logic [NREQ-1:0] req_hi;

  always_comb begin
    req_hi = '0;
    pick_o = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_hi[i] = req_i[i] && (i > int'(ptr_i));
    end
    // Lowest set bit of the above-pointer slice wins; otherwise wrap to the lowest request.
    if (|req_hi) begin
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
        if (req_hi[i]) pick_o = NREQ'(1) << i;
      end
    end else begin
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
        if (req_i[i]) pick_o = NREQ'(1) << i;
      end
    end
  end

endmodule

// File: rtl/iic_arb.sv
// Multi-requester front end for a single IIC controller: round-robin grant, one-cycle
// command pulse, busy handshake with issue and hang watchdogs, done/err/rdata return.
module iic_arb
  import iic_pkg::*;
#(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned TMO_W     = 24,
  parameter int unsigned ISSUE_MAX = ISSUE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [7*NREQ-1:0] req_dev,
  input  logic [8*NREQ-1:0] req_add,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rdata,
  output logic              err,
  output logic [1:0]        iic_command,
  output logic [6:0]        iic_dev_id,
  output logic [7:0]        iic_add,
  output logic [7:0]        iic_data_out,
  input  logic              iic_busy,
  input  logic              iic_fail,
  input  logic [7:0]        iic_data_in
);

  localparam int unsigned IssW = $clog2(ISSUE_MAX + 1);
  localparam int unsigned CntW = (TMO_W > IssW) ? TMO_W : IssW;
  localparam logic [CntW-1:0] IssueLast = CntW'(ISSUE_MAX - 1);
  // Fires on the cycle the TMO_W-bit count would reach all-ones.
  localparam logic [CntW-1:0] TmoLast = CntW'({TMO_W{1'b1}}) - CntW'(1);

  iic_state_e state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d, done_q, done_d, pick;
  logic [PTR_W-1:0] ptr_q, ptr_d, gnt_idx;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             wr_q, wr_d, err_q, err_d, win_wr;
  logic [1:0]       cmd_q, cmd_d;
  logic [6:0]       dev_q, dev_d, win_dev;
  logic [7:0]       add_q, add_d, wdata_q, wdata_d, rdata_q, rdata_d, win_add, win_wdata;

  iic_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .pick_o(pick)
  );

  always_comb begin
    win_wr    = 1'b0;
    win_dev   = '0;
    win_add   = '0;
    win_wdata = '0;
    gnt_idx   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick[i]) begin
        win_wr    = req_wr[i];
        win_dev   = req_dev[i*7 +: 7];
        win_add   = req_add[i*8 +: 8];
        win_wdata = req_wdata[i*8 +: 8];
      end
      if (gnt_q[i]) gnt_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    dev_d   = dev_q;
    add_d   = add_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cmd_d   = CMD_IDLE;
    done_d  = '0;
    err_d   = 1'b0;
    unique case (state_q)
      StArb: begin
        if (|req && !iic_busy) begin
          gnt_d   = pick;
          wr_d    = win_wr;
          dev_d   = win_dev;
          add_d   = win_add;
          wdata_d = win_wdata;
          cmd_d   = win_wr ? CMD_WR : CMD_RD;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (iic_busy) begin
          cnt_d   = '0;
          state_d = StWaitLo;
        end else if (cnt_q == IssueLast) begin
          done_d  = gnt_q;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitLo: begin
        if (!iic_busy) begin
          if (!wr_q) rdata_d = iic_data_in;
          done_d  = gnt_q;
          err_d   = iic_fail;
          state_d = StDone;
        end else if (cnt_q == TmoLast) begin
          done_d  = gnt_q;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        gnt_d   = '0;
        ptr_d   = gnt_idx;
        state_d = StArb;
      end
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StArb;
      gnt_q   <= '0;
      ptr_q   <= PTR_W'(NREQ - 1);
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      dev_q   <= '0;
      add_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cmd_q   <= CMD_IDLE;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      dev_q   <= dev_d;
      add_q   <= add_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign iic_command  = cmd_q;
  assign iic_dev_id   = dev_q;
  assign iic_add      = add_q;
  assign iic_data_out = wdata_q;

endmodule

// File: tb/tb_iic_arb.sv
// Bench for iic_arb: directed vector table, reset-in-flight sequence, then random traffic
// checked against a round-robin reference with a behavioural IIC controller model.
module tb_iic_arb;

  localparam int NReq     = 3;
  localparam int TmoW     = 8;
  localparam int IssueMax = 100;
  localparam int Budget   = 400;

  typedef enum int {MNormal, MNoResp, MHung} mode_e;

  typedef struct {
    logic       ok;
    logic [2:0] done_v;
    logic       err;
    logic [7:0] rdata;
    int         ncmd;
    logic [1:0] cmd;
    logic [6:0] dev;
    logic [7:0] add;
    logic [7:0] wd;
    logic [2:0] gnt_cmd;
    logic       multi;
    logic       unstable;
    int         lat;
    logic [2:0] done_after;
    logic [2:0] gnt_after;
  } obs_t;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] wr;
    logic [6:0] dev[3];
    logic [7:0] add[3];
    logic [7:0] wd[3];
    mode_e      mode;
    logic       fail;
    logic [7:0] data;
    logic       drop;
    logic [2:0] exp_done;
    logic [1:0] exp_cmd;
    logic [6:0] exp_dev;
    logic [7:0] exp_add;
    logic [7:0] exp_wd;
    logic       exp_err;
    logic [7:0] exp_rdata;
    int         lat_lo;
    int         lat_hi;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       req = '0;
  logic [2:0]       req_wr = '0;
  logic [6:0]       dev_a[3];
  logic [7:0]       add_a[3];
  logic [7:0]       wd_a[3];
  logic [NReq*7-1:0] req_dev;
  logic [NReq*8-1:0] req_add, req_wdata;
  logic [2:0]       gnt, done;
  logic [7:0]       rdata;
  logic             err;
  logic [1:0]       iic_command;
  logic [6:0]       iic_dev_id;
  logic [7:0]       iic_add, iic_data_out;
  logic             iic_busy = 1'b0;
  logic             iic_fail = 1'b0;
  logic [7:0]       iic_data_in = '0;

  assign req_dev   = {dev_a[2], dev_a[1], dev_a[0]};
  assign req_add   = {add_a[2], add_a[1], add_a[0]};
  assign req_wdata = {wd_a[2], wd_a[1], wd_a[0]};

  iic_arb #(
    .NREQ     (NReq),
    .TMO_W    (TmoW),
    .ISSUE_MAX(IssueMax)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_wr      (req_wr),
    .req_dev     (req_dev),
    .req_add     (req_add),
    .req_wdata   (req_wdata),
    .gnt         (gnt),
    .done        (done),
    .rdata       (rdata),
    .err         (err),
    .iic_command (iic_command),
    .iic_dev_id  (iic_dev_id),
    .iic_add     (iic_add),
    .iic_data_out(iic_data_out),
    .iic_busy    (iic_busy),
    .iic_fail    (iic_fail),
    .iic_data_in (iic_data_in)
  );

  always #5 clk = ~clk;

  // Controller model: busy rises m_lat cycles after a command, falls m_len cycles later with
  // the response; junk response values are presented while busy so early capture shows up.
  mode_e      m_mode = MNormal;
  int         m_lat = 0, m_len = 3, m_cnt = 0;
  logic       m_act = 1'b0, m_fail = 1'b0;
  logic [7:0] m_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      iic_busy = 1'b0;
      m_act    = 1'b0;
    end else begin
      if (m_act) begin
        m_cnt++;
        if (m_mode != MNoResp && m_cnt == m_lat) iic_busy = 1'b1;
        if (m_mode == MNormal && m_cnt >= m_lat + m_len) begin
          iic_busy    = 1'b0;
          iic_fail    = m_fail;
          iic_data_in = m_data;
          m_act       = 1'b0;
        end
      end
      if (iic_command != 2'b00) begin
        m_act       = 1'b1;
        m_cnt       = 0;
        iic_data_in = ~m_data;
        iic_fail    = ~m_fail;
        if (m_mode != MNoResp && m_lat == 0) iic_busy = 1'b1;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic observe(input int budget, input logic drop, output obs_t o);
    int cmd_c;
    cmd_c = 0;
    o.ok = 0; o.done_v = '0; o.err = 0; o.rdata = '0; o.ncmd = 0; o.cmd = '0;
    o.dev = '0; o.add = '0; o.wd = '0; o.gnt_cmd = '0; o.multi = 0; o.unstable = 0;
    o.lat = 0; o.done_after = '0; o.gnt_after = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if ($countones(gnt) > 1) o.multi = 1'b1;
      if (o.ncmd > 0 && {iic_dev_id, iic_add, iic_data_out} != {o.dev, o.add, o.wd})
        o.unstable = 1'b1;
      if (iic_command != 2'b00) begin
        o.ncmd++;
        o.cmd = iic_command; o.dev = iic_dev_id; o.add = iic_add; o.wd = iic_data_out;
        o.gnt_cmd = gnt;
        cmd_c = c;
        if (drop) req = '0;
      end
      if (done != '0) begin
        o.ok = 1'b1; o.done_v = done; o.err = err; o.rdata = rdata; o.lat = c - cmd_c;
        break;
      end
    end
    if (o.ok) begin
      @(negedge clk);
      o.done_after = done;
      o.gnt_after  = gnt;
    end
  endtask

  task automatic compare(input obs_t o, input logic [2:0] e_done, input logic [1:0] e_cmd,
                         input logic [6:0] e_dev, input logic [7:0] e_add, input logic [7:0] e_wd,
                         input logic e_err, input logic [7:0] e_rd, input int lat_lo,
                         input int lat_hi);
    check("done_seen", 32'(o.ok), 1);
    if (!o.ok) return;
    check("done_vec", 32'(o.done_v), 32'(e_done));
    check("cmd_pulses", o.ncmd, 1);
    check("cmd_code", 32'(o.cmd), 32'(e_cmd));
    check("dev_id", 32'(o.dev), 32'(e_dev));
    check("addr", 32'(o.add), 32'(e_add));
    check("wdata", 32'(o.wd), 32'(e_wd));
    check("err", 32'(o.err), 32'(e_err));
    check("rdata", 32'(o.rdata), 32'(e_rd));
    check("gnt_at_cmd", 32'(o.gnt_cmd), 32'(e_done));
    check("gnt_multi_hot", 32'(o.multi), 0);
    check("ctrl_unstable", 32'(o.unstable), 0);
    check("done_one_cycle", 32'(o.done_after), 0);
    check("gnt_released", 32'(o.gnt_after), 0);
    if (lat_hi != 0) begin
      n_checks++;
      if (o.lat < lat_lo || o.lat > lat_hi) begin
        n_errors++;
        $display("FAIL timeout_latency: got %0d cycles, expected %0d..%0d", o.lat, lat_lo,
                 lat_hi);
      end
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [2:0] rq, input logic [2:0] wr,
                              input logic [6:0] dev, input logic [7:0] add, input logic [7:0] wd,
                              input mode_e mode, input logic fail, input logic [7:0] data,
                              input logic drop, input int idx, input logic e_err,
                              input logic [7:0] e_rd, input int lat_lo, input int lat_hi);
    vec_t v;
    v.rst = rst; v.req = rq; v.wr = wr; v.mode = mode; v.fail = fail; v.data = data;
    v.drop = drop;
    for (int j = 0; j < 3; j++) begin
      v.dev[j] = (j == idx) ? dev : dev ^ 7'h7F;
      v.add[j] = (j == idx) ? add : add ^ 8'hFF;
      v.wd[j]  = (j == idx) ? wd : wd ^ 8'hFF;
    end
    v.exp_done = 3'b001 << idx;
    v.exp_cmd = wr[idx] ? 2'b10 : 2'b01;
    v.exp_dev = dev; v.exp_add = add; v.exp_wd = wd;
    v.exp_err = e_err; v.exp_rdata = e_rd; v.lat_lo = lat_lo; v.lat_hi = lat_hi;
    return v;
  endfunction

  vec_t       vecs[7];
  obs_t       o;
  logic       got_cmd, seen_done, noresp, exp_err;
  logic [2:0] nw;
  int         idx, ptr_ref;
  logic [7:0] rdata_ref;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Expected grant index follows the pointer history: reset leaves the pointer at 2.
    vecs[0] = mk(0, 3'b001, 3'b000, 7'h50, 8'h10, 8'h00, MNormal, 0, 8'hA5, 0, 0, 0, 8'hA5,
                 0, 0);
    vecs[1] = mk(0, 3'b010, 3'b010, 7'h21, 8'h44, 8'h3C, MNormal, 1, 8'h77, 1, 1, 1, 8'hA5,
                 0, 0);
    vecs[2] = mk(1, 3'b111, 3'b101, 7'h12, 8'h20, 8'h81, MNormal, 0, 8'h5A, 0, 0, 0, 8'h00,
                 0, 0);
    vecs[3] = mk(0, 3'b111, 3'b101, 7'h13, 8'h21, 8'h82, MNormal, 0, 8'hC3, 0, 1, 0, 8'hC3,
                 0, 0);
    vecs[4] = mk(0, 3'b111, 3'b101, 7'h14, 8'h22, 8'h83, MNormal, 1, 8'h66, 0, 2, 1, 8'hC3,
                 0, 0);
    vecs[5] = mk(0, 3'b001, 3'b000, 7'h15, 8'h23, 8'h84, MNoResp, 0, 8'h11, 0, 0, 1, 8'hC3,
                 IssueMax, IssueMax + 2);
    vecs[6] = mk(0, 3'b100, 3'b000, 7'h16, 8'h24, 8'h85, MHung, 0, 8'h22, 0, 2, 1, 8'hC3,
                 (1 << TmoW) - 1, (1 << TmoW) + 4);

    for (int j = 0; j < 3; j++) begin
      dev_a[j] = '0; add_a[j] = '0; wd_a[j] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_cmd", 32'(iic_command), 0);
    check("rst_ctrl_bus", 32'({iic_dev_id, iic_add, iic_data_out}), 0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst) do_reset();
      req = vecs[i].req; req_wr = vecs[i].wr;
      dev_a = vecs[i].dev; add_a = vecs[i].add; wd_a = vecs[i].wd;
      m_mode = vecs[i].mode; m_fail = vecs[i].fail; m_data = vecs[i].data;
      m_lat = 0; m_len = 3;
      observe(Budget, vecs[i].drop, o);
      compare(o, vecs[i].exp_done, vecs[i].exp_cmd, vecs[i].exp_dev, vecs[i].exp_add,
              vecs[i].exp_wd, vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].lat_lo,
              vecs[i].lat_hi);
    end
    req = '0;
    m_mode = MNormal;
    repeat (3) @(negedge clk);

    // Reset while the controller holds busy: no done, outputs cleared, next grant normal.
    req = 3'b001; req_wr = 3'b000;
    dev_a[0] = 7'h30; add_a[0] = 8'h31; wd_a[0] = 8'h32;
    m_mode = MHung; m_lat = 0; m_len = 3; m_data = 8'hEE; m_fail = 0;
    got_cmd = 0;
    for (int c = 0; c < 20 && !got_cmd; c++) begin
      @(negedge clk);
      if (iic_command != 2'b00) got_cmd = 1;
    end
    check("cmd_before_reset", 32'(got_cmd), 1);
    repeat (10) @(negedge clk);
    check("gnt_in_wait_lo", 32'(gnt), 32'(3'b001));
    rst_n = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 0);
    check("midrst_done_err", 32'({done, err}), 0);
    check("midrst_rdata", 32'(rdata), 0);
    check("midrst_cmd", 32'(iic_command), 0);
    check("midrst_ctrl_bus", 32'({iic_dev_id, iic_add, iic_data_out}), 0);
    req = '0; m_mode = MNormal;
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done != '0) seen_done = 1;
    end
    check("no_done_in_reset", 32'(seen_done), 0);
    rst_n = 1'b1;
    req = 3'b010; req_wr = 3'b000;
    dev_a[1] = 7'h41; add_a[1] = 8'h52; wd_a[1] = 8'h63;
    m_data = 8'h99; m_fail = 0;
    observe(Budget, 0, o);
    compare(o, 3'b010, 2'b01, 7'h41, 8'h52, 8'h63, 1'b0, 8'h99, 0, 0);
    req = '0;

    // Random traffic against a round-robin reference.
    ptr_ref = 1;
    rdata_ref = 8'h99;
    for (int t = 0; t < 40; t++) begin
      nw = 3'($urandom_range(0, 7)) & ~req;
      if ((req | nw) == 3'b000) nw = 3'b001 << $urandom_range(0, 2);
      for (int j = 0; j < 3; j++) begin
        if (nw[j]) begin
          req_wr[j] = 1'($urandom_range(0, 1));
          dev_a[j] = 7'($urandom); add_a[j] = 8'($urandom); wd_a[j] = 8'($urandom);
        end
      end
      req = req | nw;
      noresp = ($urandom_range(0, 7) == 0);
      m_mode = noresp ? MNoResp : MNormal;
      m_fail = 1'($urandom_range(0, 1));
      m_data = 8'($urandom);
      m_lat = $urandom_range(0, 3);
      m_len = $urandom_range(2, 5);
      idx = -1;
      for (int k = 1; k <= 3; k++) begin
        if (idx < 0 && req[(ptr_ref + k) % 3]) idx = (ptr_ref + k) % 3;
      end
      exp_err = noresp | m_fail;
      if (!req_wr[idx] && !noresp) rdata_ref = m_data;
      observe(Budget, 0, o);
      compare(o, 3'b001 << idx, req_wr[idx] ? 2'b10 : 2'b01, dev_a[idx], add_a[idx],
              wd_a[idx], exp_err, rdata_ref, noresp ? IssueMax : 0,
              noresp ? IssueMax + 2 : 0);
      ptr_ref = idx;
      req = req & ~(3'b001 << idx);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iic_arb.md
IIC_ARB -- requirements
Module: iic_arb

Interface
REQ-001 Parameter NREQ, default 3: number of requesters (2..4).
REQ-002 Parameter TMO_W, default 24: width of the watchdog counter.
REQ-003 Parameter ISSUE_MAX, default 4095: maximum number of clk cycles to wait for busy to rise after a command pulse.
REQ-004 clk  in  1  global clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req  in  NREQ  per-requester request level; held until its done pulse.
REQ-007 req_wr  in  NREQ  per-requester operation select: 1 = write, 0 = read.
REQ-008 req_dev  in  7*NREQ  per-requester 7-bit device id.
REQ-009 req_add  in  8*NREQ  per-requester word address.
REQ-010 req_wdata  in  8*NREQ  per-requester write data.
REQ-011 gnt  out  NREQ  one-hot grant; held for the whole transaction.
REQ-012 done  out  NREQ  one-cycle completion pulse to the granted requester.
REQ-013 rdata  out  8  read data; valid in the done cycle and held until the next done.
REQ-014 err  out  1  error flag for the completed transaction; valid with done.
REQ-015 iic_command  out  2  to the controller: bit1 = write, bit0 = read.
REQ-016 iic_dev_id  out  7  to the controller.
REQ-017 iic_add  out  8  to the controller.
REQ-018 iic_data_out  out  8  to the controller.
REQ-019 iic_busy  in  1  from the controller.
REQ-020 iic_fail  in  1  from the controller.
REQ-021 iic_data_in  in  8  from the controller.

Function
REQ-022 FSM states: ARB, ISSUE, WAIT_HI, WAIT_LO, DONE.
REQ-023 ARB: when any req bit is set and iic_busy=0, select the winner round-robin starting after the last granted index, register gnt and the winner's dev/add/wdata/wr, and go to ISSUE next cycle.
REQ-024 ISSUE: drive iic_command=2'b10 (write) or 2'b01 (read) for exactly one cycle, then go to WAIT_HI.
REQ-025 iic_command shall be 2'b00 in every state except ISSUE; both bits shall never be set together.
REQ-026 WAIT_HI: on iic_busy=1 go to WAIT_LO; if ISSUE_MAX cycles elapse without busy, set the error and go to DONE.
REQ-027 WAIT_LO: on iic_busy=0, capture iic_data_in (read only) and iic_fail, then go to DONE.
REQ-028 WAIT_LO watchdog: a TMO_W-bit counter saturating at all-ones forces the error and DONE.
REQ-029 DONE: pulse done[granted]=1 for one cycle, drive err, clear gnt, update the round-robin pointer, and return to ARB.
REQ-030 err = captured iic_fail OR any timeout; a write with iic_fail=1 reports err=1.
REQ-031 iic_dev_id, iic_add and iic_data_out shall stay stable from ISSUE through DONE.
REQ-032 A requester dropping req mid-transaction shall not abort it; the done pulse is still issued.
REQ-033 Simultaneous requests: exactly one grant. With the pointer after index k, index k+1 mod NREQ has highest priority.
REQ-034 rdata is not updated on writes or on timeouts.
REQ-035 Minimum gap between transactions: one ARB cycle after DONE.

Reset
REQ-036 In reset: state=ARB, gnt=0, done=0, err=0, rdata=0, iic_command=0, iic_dev_id=0, iic_add=0, iic_data_out=0, round-robin pointer=NREQ-1 (so index 0 wins first), counters=0.
REQ-037 Reset mid-transaction returns to ARB immediately with no done pulse; the controller recovers via its own reset.

Structure
REQ-038 Shared package iic_pkg holds the FSM state encodings, the command encodings (CMD_IDLE=2'b00, CMD_RD=2'b01, CMD_WR=2'b10) and the default ISSUE_MAX.
REQ-039 The round-robin pick logic shall be one sub-module, iic_rr_pick (inputs: request vector and pointer; output: one-hot winner), purely combinational.
REQ-040 Target size is 150-300 lines of RTL, with no latches and every register on clk with async rst_n.

Verification
REQ-041 Single read: req[0] with dev=7'h50, add=8'h10; the controller model returns 8'hA5 and fail=0 -> one iic_command=01 pulse, done[0] pulse, rdata=A5, err=0.
REQ-042 Single write with fail: req[1], wr=1, wdata=8'h3C; the model asserts fail=1 -> iic_command=10 for one cycle, done[1] pulse, err=1, rdata unchanged.
REQ-043 Contention: req=3'b111 held for three transactions after reset -> grant order 0, 1, 2, one done per transaction, never two gnt bits set at once.
REQ-044 No-response: the model never raises busy -> err=1 and done after ISSUE_MAX cycles, then the arbiter returns to ARB.
REQ-045 Hung busy: busy stays high -> watchdog fires at 2^TMO_W-1 cycles with err=1 (use TMO_W=8 in this test).
REQ-046 Reset asserted in WAIT_LO -> all outputs return to reset values within one cycle, no done pulse, and the next request is granted normally.
